// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant arbiters.
//   arb_state_e  : arbiter FSM states (IDLE = no owner, GRANT = one owner)
//   pick_t       : result of a rotating priority search (found flag + index)
//   rr_pick()    : rotating priority search over the low n bits of a request
//                  vector, starting at ptr and wrapping from n-1 back to 0
package arb_pkg;

  typedef enum logic [0:0] {IDLE, GRANT} arb_state_e;

  localparam int N_REQ_DEFAULT    = 4;
  localparam int MAX_HOLD_DEFAULT = 8;

  // Widest request vector the shared search supports.
  localparam int PICK_MAX = 32;
  localparam int PICK_W   = 5;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // The loop always runs over PICK_MAX positions so it unrolls to fixed
  // hardware; positions at or beyond n are masked out. Because ptr < n and
  // only k < n is considered, a single subtraction performs the wrap.
  function automatic pick_t rr_pick(input logic [PICK_MAX-1:0] req,
                                    input logic [PICK_W-1:0]   ptr,
                                    input int                  n);
    pick_t res;
    int    j;
    res.found = 1'b0;
    res.idx   = '0;
    for (int k = 0; k < PICK_MAX; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if ((k < n) && !res.found && req[j[PICK_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[PICK_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational rotating priority selector.
// Finds the first set request bit at or after ptr, wrapping past N_REQ-1.
//   req   : request vector, bit i = requester i
//   ptr   : index with highest priority this evaluation
//   sel   : winning index (0 when found is low)
//   found : at least one request bit is set
// N_REQ must lie in 2..32.
module rr_pick_comb
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic                     found
);

  pick_t pick;

  // Widen to the shared search width, then narrow the index back down.
  always_comb begin
    pick  = rr_pick(PICK_MAX'(req), PICK_W'(ptr), N_REQ);
    sel   = pick.idx[$clog2(N_REQ)-1:0];
    found = pick.found;
  end

endmodule

// File: rtl/rr_gnt_arbiter.sv
// Round-robin arbiter with registered one-hot grant and tenure limit.
// An owner keeps the grant while it requests, for at most MAX_HOLD cycles.
// Every release is followed by exactly one all-zero bubble cycle, during
// which the next owner is chosen starting just after the previous owner.
//   clk       : clock, all state updates on rising edge
//   rstn      : synchronous active-low reset
//   req       : request vector, bit i = requester i
//   gnt       : registered grant, one-hot or zero
//   gnt_valid : registered, high iff gnt is non-zero
//   gnt_id    : registered owner index, 0 when no grant
//   hold_cnt  : registered cycles held by current owner (1 on first cycle)
module rr_gnt_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic [7:0]               hold_cnt
);

  localparam int IDW = $clog2(N_REQ);

  arb_state_e     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick_sel;
  logic           pick_found;
  logic           release_now;
  logic [IDW-1:0] ptr_next;

  rr_pick_comb #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .sel   (pick_sel),
    .found (pick_found)
  );

  // An owner loses the grant when it drops its request or has used its
  // full tenure; both conditions lead to the same release action.
  always_comb begin
    release_now = !req[gnt_id] || (hold_cnt == 8'(MAX_HOLD));
    ptr_next    = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  // Single registered FSM. The pointer moves only on release, so a
  // requester that keeps asking is reached within N_REQ-1 tenures.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      hold_cnt  <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= GRANT;
            gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_sel;
            gnt_valid <= 1'b1;
            gnt_id    <= pick_sel;
            hold_cnt  <= 8'd1;
          end
        end
        GRANT: begin
          if (release_now) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            hold_cnt  <= '0;
            ptr       <= ptr_next;
          end else begin
            hold_cnt  <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          gnt_id    <= '0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_gnt_arbiter.sv
// Self-checking bench for rr_gnt_arbiter.
// Two instances: dut (MAX_HOLD=8) and dut2 (MAX_HOLD=2). Directed vector
// tables cover reset, release, tenure limit, noise and reset mid-grant;
// a hand sequence covers rotation; a random phase compares both instances
// against a tenure-level reference model and checks the grant invariants.
module tb_rr_gnt_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rstn, rstn2;
  logic [3:0] req, req2;
  logic [3:0] gnt, gnt2;
  logic       gnt_valid, gnt_valid2;
  logic [1:0] gnt_id, gnt_id2;
  logic [7:0] hold_cnt, hold_cnt2;

  always #5 clk = ~clk;

  rr_gnt_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rstn(rstn), .req(req),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .hold_cnt(hold_cnt)
  );

  rr_gnt_arbiter #(.N_REQ(4), .MAX_HOLD(2)) dut2 (
    .clk(clk), .rstn(rstn2), .req(req2),
    .gnt(gnt2), .gnt_valid(gnt_valid2), .gnt_id(gnt_id2), .hold_cnt(hold_cnt2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] hold;
  } vec_t;

  vec_t vecs[$];

  // Tenure-level reference model state per instance (0: dut, 1: dut2).
  int owner [2];
  int tenure[2];
  int prio  [2];
  int limit [2];
  logic [3:0] prev_gnt[2];

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic applyStimulus(input logic r, input logic [3:0] q,
                               input logic r2, input logic [3:0] q2);
    @(negedge clk);
    rstn  = r;
    req   = q;
    rstn2 = r2;
    req2  = q2;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic r, input logic [3:0] q,
                        input logic [3:0] g, input logic [7:0] h);
    vec_t v;
    v.rstn = r;
    v.req  = q;
    v.gnt  = g;
    v.hold = h;
    vecs.push_back(v);
  endtask

  function automatic int idOf(input logic [3:0] g);
    int id = 0;
    for (int i = 0; i < N; i++) if (g[i]) id = i;
    return id;
  endfunction

  // Advance the model by one clock: who owns the grant, for how long, and
  // where the next search starts.
  task automatic modelStep(input int u, input logic r, input logic [3:0] q);
    if (!r) begin
      owner[u] = -1; tenure[u] = 0; prio[u] = 0;
    end else if (owner[u] < 0) begin
      for (int k = 0; k < N; k++) begin
        if (owner[u] < 0 && q[(prio[u] + k) % N]) begin
          owner[u]  = (prio[u] + k) % N;
          tenure[u] = 1;
        end
      end
    end else if (!q[owner[u]] || tenure[u] == limit[u]) begin
      prio[u]   = (owner[u] + 1) % N;
      owner[u]  = -1;
      tenure[u] = 0;
    end else begin
      tenure[u]++;
    end
  endtask

  task automatic checkInvariants(input int u, input logic [3:0] g,
                                 input logic v);
    checkOutput("onehot0", 32'($onehot0(g)), 32'd1);
    checkOutput("valid_or", 32'(v), 32'(|g));
    checkOutput("no_handoff",
                32'((prev_gnt[u] != 4'h0) && (g != 4'h0) && (g != prev_gnt[u])),
                32'd0);
    prev_gnt[u] = g;
  endtask

  initial begin
    logic [3:0] rot_gnt [15];
    logic [7:0] rot_hold[15];
    logic [3:0] exp_g;
    logic       r;
    logic [3:0] q;

    rstn = 1'b0; req = 4'h0; rstn2 = 1'b0; req2 = 4'h0;
    limit[0] = 8; limit[1] = 2;

    // Reset held with all requests present; first grant goes to 0.
    for (int i = 0; i < 3; i++) addVec(1'b0, 4'hF, 4'h0, 8'd0);
    addVec(1'b1, 4'hF, 4'h1, 8'd1);
    addVec(1'b1, 4'h0, 4'h0, 8'd0);
    addVec(1'b1, 4'h0, 4'h0, 8'd0);
    // Single requester, then pointer lands on 3.
    addVec(1'b1, 4'h4, 4'h4, 8'd1);
    addVec(1'b1, 4'h4, 4'h4, 8'd2);
    addVec(1'b1, 4'h4, 4'h4, 8'd3);
    addVec(1'b1, 4'h0, 4'h0, 8'd0);
    addVec(1'b1, 4'hC, 4'h8, 8'd1);
    addVec(1'b1, 4'h0, 4'h0, 8'd0);
    // Tenure limit of 8 with sole requester 1.
    for (int i = 1; i <= 8; i++) addVec(1'b1, 4'h2, 4'h2, 8'(i));
    addVec(1'b1, 4'h2, 4'h0, 8'd0);
    addVec(1'b1, 4'h2, 4'h2, 8'd1);
    addVec(1'b1, 4'h0, 4'h0, 8'd0);
    // Owner 0 with non-owner noise, released only by the tenure limit.
    addVec(1'b1, 4'h1, 4'h1, 8'd1);
    for (int i = 2; i <= 8; i++)
      addVec(1'b1, (i % 2 == 0) ? 4'hF : 4'h1, 4'h1, 8'(i));
    addVec(1'b1, 4'hB, 4'h0, 8'd0);
    addVec(1'b1, 4'h0, 4'h0, 8'd0);
    // Owner 3 up to hold 5, reset mid-grant, pointer back at 0.
    for (int i = 1; i <= 5; i++) addVec(1'b1, 4'h8, 4'h8, 8'(i));
    addVec(1'b0, 4'h8, 4'h0, 8'd0);
    addVec(1'b1, 4'hA, 4'h2, 8'd1);
    addVec(1'b1, 4'h0, 4'h0, 8'd0);

    $display("[TB] directed vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].req, 1'b0, 4'h0);
      checkOutput($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      checkOutput($sformatf("vec%0d_hold", i), 32'(hold_cnt), 32'(vecs[i].hold));
      checkOutput($sformatf("vec%0d_valid", i), 32'(gnt_valid), 32'(vecs[i].gnt != 4'h0));
      checkOutput($sformatf("vec%0d_id", i), 32'(gnt_id), 32'(idOf(vecs[i].gnt)));
      checkOutput($sformatf("vec%0d_dut2_idle", i), 32'(gnt2), 32'd0);
    end

    // Rotation with MAX_HOLD=2 and all four requesting.
    rot_gnt  = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0,
                 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0};
    rot_hold = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0,
                 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0};
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b1, 4'hF);
      checkOutput($sformatf("rot%0d_gnt", i), 32'(gnt2), 32'(rot_gnt[i]));
      checkOutput($sformatf("rot%0d_hold", i), 32'(hold_cnt2), 32'(rot_hold[i]));
    end

    // Random phase: shared inputs, per-instance model.
    for (int u = 0; u < 2; u++) prev_gnt[u] = 4'h0;
    q = 4'h0;
    for (int c = 0; c < 600; c++) begin
      r = (c == 0) ? 1'b0 : ($urandom_range(39) != 0);
      for (int b = 0; b < N; b++) if ($urandom_range(3) == 0) q[b] = ~q[b];
      applyStimulus(r, q, r, q);
      modelStep(0, r, q);
      modelStep(1, r, q);

      exp_g = (owner[0] < 0) ? 4'h0 : 4'(1 << owner[0]);
      checkOutput("rnd_gnt", 32'(gnt), 32'(exp_g));
      checkOutput("rnd_hold", 32'(hold_cnt), 32'(tenure[0]));
      checkOutput("rnd_id", 32'(gnt_id), 32'((owner[0] < 0) ? 0 : owner[0]));
      checkInvariants(0, gnt, gnt_valid);

      exp_g = (owner[1] < 0) ? 4'h0 : 4'(1 << owner[1]);
      checkOutput("rnd2_gnt", 32'(gnt2), 32'(exp_g));
      checkOutput("rnd2_hold", 32'(hold_cnt2), 32'(tenure[1]));
      checkOutput("rnd2_id", 32'(gnt_id2), 32'((owner[1] < 0) ? 0 : owner[1]));
      checkInvariants(1, gnt2, gnt_valid2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
